// File: rtl/genius_jogo_param_if.sv
// Board-side bundle of the memory-game core: player controls in, display and status out.
interface genius_jogo_param_if #(
  parameter int unsigned N_BOTOES = 4
);
  logic                jogar;
  logic                modo;
  logic [N_BOTOES-1:0] botoes;
  logic [N_BOTOES-1:0] leds;
  logic                ganhou;
  logic                perdeu;
  logic                pronto;
  logic [3:0]          db_rodada;
  logic [3:0]          db_jogada;
  logic [3:0]          db_estado;
  logic                db_timeout;

  modport master (
    output jogar, modo, botoes,
    input  leds, ganhou, perdeu, pronto, db_rodada, db_jogada, db_estado, db_timeout
  );

  modport slave (
    input  jogar, modo, botoes,
    output leds, ganhou, perdeu, pronto, db_rodada, db_jogada, db_estado, db_timeout
  );
endinterface

// File: rtl/genius_jogo_param.sv
// Simon-style memory-game core: LFSR-generated colour sequence, LED playback,
// press checking with a per-press timeout, and a newest-element-only mode.
module genius_jogo_param #(
  parameter int unsigned N_BOTOES  = 4,
  parameter int unsigned N_RODADAS = 16,
  parameter logic [15:0] SEED      = 16'h0001,
  parameter int unsigned TIMEOUT   = 5000,
  parameter int unsigned T_LED     = 500,
  parameter int unsigned T_GAP     = 250
) (
  input logic                clock,
  input logic                reset,
  genius_jogo_param_if.slave bus
);
  localparam int unsigned LOG2N = $clog2(N_BOTOES);
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam int unsigned CW    = $clog2(((T_LED > T_GAP) ? T_LED : T_GAP) + 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    MOSTRA      = 4'd2,
    ESPERA      = 4'd3,
    COMPARA     = 4'd4,
    SOLTA_J     = 4'd5,
    SOLTA_R     = 4'd6,
    FIM_GANHOU  = 4'd7,
    FIM_PERDEU  = 4'd8,
    FIM_TIMEOUT = 4'd9
  } estado_t;

  estado_t             estado_q;
  logic [15:0]         lfsr_q;
  logic [15:0]         lfsr_d;
  logic                modo_q;
  logic                gap_q;
  logic                ganhou_q;
  logic                perdeu_q;
  logic                pronto_q;
  logic                timeout_q;
  logic [3:0]          rodada_q;
  logic [3:0]          jogada_q;
  logic [3:0]          elem_q;
  logic [CW-1:0]       cnt_q;
  logic [TW-1:0]       tmo_q;
  logic [N_BOTOES-1:0] botoes_q;
  logic [N_BOTOES-1:0] press_q;
  logic [N_BOTOES-1:0] leds_q;
  logic [N_BOTOES-1:0] alvo_d;
  logic                pressao;

  assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign alvo_d  = N_BOTOES'(1) << lfsr_q[LOG2N-1:0];
  assign pressao = (botoes_q == '0) && (bus.botoes != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= INICIAL;
      lfsr_q    <= SEED;
      modo_q    <= 1'b0;
      gap_q     <= 1'b0;
      ganhou_q  <= 1'b0;
      perdeu_q  <= 1'b0;
      pronto_q  <= 1'b0;
      timeout_q <= 1'b0;
      rodada_q  <= '0;
      jogada_q  <= '0;
      elem_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      botoes_q  <= '0;
      press_q   <= '0;
      leds_q    <= '0;
    end else begin
      botoes_q <= bus.botoes;
      case (estado_q)
        INICIAL: begin
          leds_q <= '0;
          if (bus.jogar) estado_q <= PREPARA;
        end
        PREPARA: begin
          rodada_q <= '0;
          jogada_q <= '0;
          modo_q   <= bus.modo;
          lfsr_q   <= SEED;
          elem_q   <= '0;
          cnt_q    <= '0;
          gap_q    <= 1'b0;
          leds_q   <= '0;
          estado_q <= MOSTRA;
        end
        MOSTRA: begin
          if (modo_q && !gap_q && (elem_q != rodada_q)) begin
            // hard mode: walk to the newest element with the LEDs dark
            lfsr_q <= lfsr_d;
            elem_q <= elem_q + 4'd1;
            leds_q <= '0;
          end else if (!gap_q) begin
            leds_q <= alvo_d;
            if (cnt_q == CW'(T_LED - 1)) begin
              cnt_q <= '0;
              gap_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            leds_q <= '0;
            if (cnt_q == CW'(T_GAP - 1)) begin
              cnt_q <= '0;
              gap_q <= 1'b0;
              if (elem_q == rodada_q) begin
                estado_q <= ESPERA;
                jogada_q <= '0;
                lfsr_q   <= SEED;
                tmo_q    <= '0;
              end else begin
                elem_q <= elem_q + 4'd1;
                lfsr_q <= lfsr_d;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ESPERA: begin
          leds_q <= bus.botoes;
          // a press arriving on the expiry cycle still counts
          if (pressao) begin
            press_q  <= bus.botoes;
            estado_q <= COMPARA;
          end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
            leds_q    <= '0;
            perdeu_q  <= 1'b1;
            timeout_q <= 1'b1;
            pronto_q  <= 1'b1;
            estado_q  <= FIM_TIMEOUT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        COMPARA: begin
          leds_q <= bus.botoes;
          if (press_q != alvo_d) begin
            leds_q   <= '0;
            perdeu_q <= 1'b1;
            pronto_q <= 1'b1;
            estado_q <= FIM_PERDEU;
          end else if (jogada_q != rodada_q) begin
            jogada_q <= jogada_q + 4'd1;
            lfsr_q   <= lfsr_d;
            tmo_q    <= '0;
            estado_q <= SOLTA_J;
          end else begin
            estado_q <= SOLTA_R;
          end
        end
        SOLTA_J: begin
          leds_q <= bus.botoes;
          if (tmo_q < TW'(TIMEOUT)) tmo_q <= tmo_q + TW'(1);
          if (bus.botoes == '0) estado_q <= ESPERA;
        end
        SOLTA_R: begin
          leds_q <= bus.botoes;
          if (bus.botoes == '0) begin
            if (rodada_q == 4'(N_RODADAS - 1)) begin
              leds_q   <= '0;
              ganhou_q <= 1'b1;
              pronto_q <= 1'b1;
              estado_q <= FIM_GANHOU;
            end else begin
              rodada_q <= rodada_q + 4'd1;
              lfsr_q   <= SEED;
              elem_q   <= '0;
              cnt_q    <= '0;
              gap_q    <= 1'b0;
              leds_q   <= '0;
              estado_q <= MOSTRA;
            end
          end
        end
        FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
          leds_q <= '0;
          if (bus.jogar) begin
            ganhou_q  <= 1'b0;
            perdeu_q  <= 1'b0;
            pronto_q  <= 1'b0;
            timeout_q <= 1'b0;
            estado_q  <= PREPARA;
          end
        end
        default: estado_q <= INICIAL;
      endcase
    end
  end

  assign bus.leds       = leds_q;
  assign bus.ganhou     = ganhou_q;
  assign bus.perdeu     = perdeu_q;
  assign bus.pronto     = pronto_q;
  assign bus.db_rodada  = rodada_q;
  assign bus.db_jogada  = jogada_q;
  assign bus.db_estado  = estado_q;
  assign bus.db_timeout = timeout_q;
endmodule

// File: doc/genius_jogo_param.md
Name: genius_jogo_param

Overview:
- Parametrised memory-game core (Genius/Simon), the successor to circuito_jogo_base.
- Generates the colour sequence internally from an LFSR instead of a fixed ROM, so no sequence storage is needed.
- Plays the sequence back on the LEDs, checks player presses, and enforces a per-press timeout.
- Adds a "hard" mode that shows only the newest element. Sits between the button/LED board I/O and the 7-segment debug decoders.

Parameters:
- N_BOTOES, 4, number of buttons/LEDs; must be 2, 4 or 8. LOG2N = log2(N_BOTOES).
- N_RODADAS, 16, rounds needed to win (1..16).
- SEED, 16'h0001, LFSR seed; must be non-zero.
- TIMEOUT, 5000, clock cycles allowed per press while waiting.
- T_LED, 500, cycles each sequence element is lit.
- T_GAP, 250, dark cycles after each displayed element.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- jogar  in  1  start/restart request (level-sampled).
- modo  in  1  0 = replay the full sequence each round; 1 = show only the newest element. Sampled once, at start.
- botoes  in  N_BOTOES  player buttons, active-high.
- leds  out  N_BOTOES  one-hot display / press echo.
- ganhou  out  1  game won.
- perdeu  out  1  game lost (wrong press or timeout).
- pronto  out  1  game finished.
- db_rodada  out  4  current round index (0-based).
- db_jogada  out  4  current press index within the round.
- db_estado  out  4  state encoding, as listed under the FSM below.
- db_timeout  out  1  loss was caused by timeout.

Behaviour:

Reset (asynchronous, active-high):
- State INICIAL.
- All outputs 0; rodada = 0, jogada = 0.
- lfsr = SEED; modo register = 0.

LFSR and sequence:
- 16-bit Fibonacci, shifts left each step; new bit0 = b15^b13^b12^b10.
- Element k = lfsr[LOG2N-1:0] after k steps from SEED.
- Expected press for element k = one-hot(element k).
- At the start of each display phase and each answer phase the LFSR is reloaded with SEED. It is stepped once per element consumed.

Press detection:
- botoes is registered once. A press is a cycle where the registered value is 0 and the current value is non-zero.
- The press value must equal the expected one-hot exactly; multiple bits high counts as wrong.
- After a correct press, the next press is accepted only after botoes returns to 0.

FSM states (db_estado encoding in parentheses):
- INICIAL (0): outputs 0; jogar=1 -> PREPARA.
- PREPARA (1): one cycle; rodada=0; latch modo.
- MOSTRA (2):
  - Reload SEED.
  - modo=0: elements 0..rodada are displayed. modo=1: the LFSR is stepped silently to element rodada, then only that element is displayed.
  - Each displayed element: leds = one-hot for exactly T_LED cycles, then leds = 0 for exactly T_GAP cycles.
  - Then -> ESPERA with jogada=0 and LFSR reloaded.
- ESPERA (3):
  - leds = botoes (echo); timeout counter increments each cycle.
  - Press -> COMPARA.
  - Counter reaches TIMEOUT with no press -> FIM_TIMEOUT. A press in that same cycle wins over the timeout.
- COMPARA (4): one cycle.
  - Wrong -> FIM_PERDEU.
  - Correct and jogada < rodada -> SOLTA_J: jogada+1, LFSR step, timeout counter cleared.
  - Correct and jogada == rodada -> SOLTA_R.
- SOLTA_J (5): wait for botoes==0 -> ESPERA. The timeout counter runs here too.
- SOLTA_R (6): wait for botoes==0.
  - If rodada == N_RODADAS-1 -> FIM_GANHOU.
  - Otherwise rodada+1 -> MOSTRA.
- FIM_GANHOU (7) / FIM_PERDEU (8) / FIM_TIMEOUT (9):
  - pronto=1. ganhou=1 / perdeu=1 / perdeu=1 and db_timeout=1 respectively.
  - Held until jogar=1 -> PREPARA, which clears ganhou, perdeu and db_timeout.

Boundaries:
- jogar is ignored in all states except INICIAL and the FIM states.
- Reset mid-display or mid-wait aborts immediately to INICIAL.
- N_RODADAS=1: a single correct press wins.

Test Plan:
Common setup: N_BOTOES=4, N_RODADAS=4, SEED=16'h0001, TIMEOUT=50, T_LED=4, T_GAP=2. The resulting expected sequence is buttons 1,2,0,0 (one-hot 0010, 0100, 0001, 0001).

1. Reset, jogar pulse 5 cycles, modo=0; answer every round correctly (each press held 5 cycles, released 5 cycles) -> round r shows r+1 elements at 4 cycles each. Then ganhou=1, pronto=1, perdeu=0, db_rodada=3.
2. Same as scenario 1, but round 2 press 1 = 0001 -> perdeu=1, pronto=1, db_timeout=0, ganhou=0.
3. In round 3, wait 51 cycles before press 1 -> FIM_TIMEOUT: perdeu=1, db_timeout=1, db_estado=9.
4. modo=1, round 2 -> exactly one 4-cycle flash of 0001, preceded by no flashes. Full answer 0010, 0100, 0001 is accepted.
5. Press 0110 in round 0 -> perdeu=1. Then a jogar pulse -> perdeu cleared, round 0 shows 0010 again.
6. Assert reset during MOSTRA of round 2 -> leds=0, all flags 0, db_estado=0 on the same cycle. jogar restarts at round 0.
